vram_arbiter: RTL
=================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter FB_W, default 160: framebuffer width in stored pixels.
REQ-002 Parameter SHIFT, default 2: display-to-framebuffer scale as a power of two; each stored pixel covers 4x4 screen pixels.
REQ-003 Parameter DW, default 8: data and pixel width; the address width is fixed at 16.
REQ-004 clk  in  1  the single clock, rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 hpos, vpos  in  16 each  beam position from the sync generator.
REQ-007 display_on  in  1  the beam is in the visible area.
REQ-008 cpu_req  in  1  CPU access request, held high until cpu_ack is seen.
REQ-009 cpu_we  in  1  1 means write, 0 means read; valid while cpu_req is high.
REQ-010 cpu_addr  in  16  CPU address.
REQ-011 cpu_wdata  in  DW  CPU write data.
REQ-012 cpu_ack  out  1  one-cycle completion pulse.
REQ-013 cpu_rdata  out  DW  read data, valid when cpu_ack is high.
REQ-014 ram_addr  out  16  single-port RAM address.
REQ-015 ram_we  out  1  RAM write enable.
REQ-016 ram_wdata  out  DW  RAM write data.
REQ-017 ram_rdata  in  DW  RAM read data; the RAM registers its read, so data arrives one cycle after the address.
REQ-018 pix_data  out  DW  fetched pixel value for the display.
REQ-019 pix_valid  out  1  pix_data belongs to the visible area.

Function
REQ-020 A cycle SHALL be a display slot when display_on=1 and hpos[SHIFT-1:0]=0.
REQ-021 In a display slot the block SHALL drive ram_addr = ((vpos>>SHIFT)*FB_W + (hpos>>SHIFT)) truncated to 16 bits, with ram_we=0.
REQ-022 Display slots SHALL have absolute priority; the CPU SHALL never be granted in a display slot.
REQ-023 The FSM SHALL have three states: IDLE, WAIT and ACK.
REQ-024 Grant: when the state is IDLE, cpu_req=1 and the cycle is not a display slot, the block SHALL drive ram_addr=cpu_addr, ram_we=cpu_we and ram_wdata=cpu_wdata combinationally in that cycle, then move to WAIT.
REQ-025 WAIT SHALL last one cycle: the block SHALL register cpu_rdata <= ram_rdata, drive no CPU address, and go to ACK.
REQ-026 ACK SHALL last one cycle: cpu_ack=1 and no grant, then return to IDLE.
REQ-027 The requester SHALL deassert cpu_req or present a new request at the edge that ends the ACK cycle; a request still high in IDLE SHALL be treated as a new request.
REQ-028 For a write, cpu_rdata SHALL still update in WAIT, and its value is don't-care.
REQ-029 Latency from grant to cpu_ack SHALL be exactly 2 cycles; the maximum rate is one access per 3 cycles.
REQ-030 A request arriving in a display slot SHALL wait until the first non-slot IDLE cycle; at most one cycle of delay occurs per display slot.
REQ-031 In cycles that are neither a display slot nor a grant, outputs SHALL be ram_we=0, ram_addr=0 and ram_wdata=0.
REQ-032 Pixel pipeline, display slot at cycle S: ram_rdata is valid in cycle S+1 and SHALL be registered into pix_data, visible in cycle S+2.
REQ-033 pix_data SHALL hold its value between slots.
REQ-034 pix_valid SHALL equal display_on delayed by exactly 2 cycles.
REQ-035 The display slot in the WAIT or ACK cycle of a CPU access SHALL proceed normally, since the RAM port is free in those cycles.
REQ-036 Address arithmetic SHALL be unsigned, with the product and sum formed at 16 bits or wider and truncated to 16 bits without saturation.

Reset
REQ-037 When reset=1 at a clock edge, the block SHALL set the state to IDLE and set cpu_ack, cpu_rdata, pix_data, pix_valid and both delay stages to 0.
REQ-038 During the reset cycle, ram_we SHALL be 0.
REQ-039 Reset in WAIT or ACK SHALL abort the access with no cpu_ack; a write already issued at grant stays committed in RAM.

Verification
REQ-040 Scenario: idle beam with display_on=0, write cpu_addr=0x0010, cpu_wdata=0xA5 -> ram_we=1 in the grant cycle, cpu_ack 2 cycles later, then a read of 0x0010 returns cpu_rdata=0xA5 with cpu_ack.
REQ-041 Scenario: cpu_req rises in a display slot with hpos=4, vpos=8 -> ram_addr=2*160+1=321 and ram_we=0 that cycle, CPU granted the next cycle, cpu_ack 2 cycles after the grant.
REQ-042 Scenario: RAM preloaded with addr 321 = 0x3C, beam at hpos=4, vpos=8, display_on=1 -> pix_data=0x3C and pix_valid=1 two cycles later, held until the next slot.
REQ-043 Scenario: cpu_req held high continuously -> grants 3 cycles apart, exactly one cpu_ack pulse per access, and no grant ever coincides with a display slot.
REQ-044 Scenario: reset asserted in WAIT of a read -> no cpu_ack, state IDLE, all outputs 0 the following cycle.
REQ-045 Scenario: hpos=636, vpos=476 -> ram_addr=119*160+159=19199, with no overflow.

Source files
------------

// File: rtl/vram_arbiter.sv
// Shares one single-port VRAM between display refresh and a CPU port.
// Display slots always win; the CPU gets a 3-cycle grant/wait/ack access.
module vram_arbiter #(
  parameter int FB_W  = 160,
  parameter int SHIFT = 2,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [15:0]   hpos,
  input  logic [15:0]   vpos,
  input  logic          display_on,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [15:0]   cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic [15:0]   ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic [DW-1:0] pix_data,
  output logic          pix_valid
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_t;

  localparam logic [15:0] LOW_MASK = 16'((32'd1 << SHIFT) - 32'd1);

  state_t      state;
  state_t      state_next;
  logic        slot;
  logic        grant;
  logic [31:0] prod;
  logic [15:0] disp_addr;
  logic        slot_d;
  logic        on_d;

  assign slot = display_on && ((hpos & LOW_MASK) == 16'd0);

  // Full-width product, then wrap to the 16-bit RAM address space.
  assign prod = 32'(vpos >> SHIFT) * 32'(FB_W) + 32'(hpos >> SHIFT);
  assign disp_addr = prod[15:0];

  assign grant = (state == IDLE) && cpu_req && !slot && !reset;
  assign cpu_ack = (state == ACK);

  always_comb begin
    state_next = state;
    ram_addr   = 16'd0;
    ram_we     = 1'b0;
    ram_wdata  = '0;
    unique case (state)
      IDLE: if (grant) state_next = WAIT;
      WAIT: state_next = ACK;
      ACK:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (slot) begin
      ram_addr = disp_addr;
    end else if (grant) begin
      ram_addr  = cpu_addr;
      ram_we    = cpu_we;
      ram_wdata = cpu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cpu_rdata <= '0;
      pix_data  <= '0;
      pix_valid <= 1'b0;
      slot_d    <= 1'b0;
      on_d      <= 1'b0;
    end else begin
      state     <= state_next;
      slot_d    <= slot;
      on_d      <= display_on;
      pix_valid <= on_d;
      if (state == WAIT) cpu_rdata <= ram_rdata;
      if (slot_d) pix_data <= ram_rdata;
    end
  end

endmodule
